// File: rtl/edge_event_capture_pkg.sv
// Shared constants for the edge event capture block.
// Mode encoding and filter counter sizing.
package edge_event_pkg;

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;

  function automatic int cnt_width(input int filter_len);
    return $clog2(filter_len + 1);
  endfunction

endpackage

// File: rtl/edge_event_capture_if.sv
// Control and status bundle of the edge event capture block.
// The master drives controls, the slave reports events.
interface edge_event_capture_if #(
  parameter int WIDTH = 32
);
  import edge_event_pkg::*;

  logic               ena;
  logic [WIDTH-1:0]   in;
  logic [2*WIDTH-1:0] mode;
  logic [WIDTH-1:0]   clr;
  logic [WIDTH-1:0]   irq_en;
  logic [WIDTH-1:0]   level;
  logic [WIDTH-1:0]   rising;
  logic [WIDTH-1:0]   falling;
  logic [WIDTH-1:0]   both;
  logic [WIDTH-1:0]   pending;
  logic [WIDTH-1:0]   overrun;
  logic               irq;

  modport master (
    output ena, in, mode, clr, irq_en,
    input  level, rising, falling, both,
    input  pending, overrun, irq
  );

  modport slave (
    input  ena, in, mode, clr, irq_en,
    output level, rising, falling, both,
    output pending, overrun, irq
  );

endinterface

// File: rtl/edge_event_capture_chan.sv
// One channel: synchroniser, debounce filter,
// edge pulses and sticky pending/overrun flags.
module edge_chan
  import edge_event_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter int   FILTER_LEN  = 4,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       ena_i,
  input  logic       in_i,
  input  logic [1:0] mode_i,
  input  logic       clr_i,
  output logic       level_o,
  output logic       rising_o,
  output logic       falling_o,
  output logic       pending_o,
  output logic       overrun_o
);

  localparam int CW = cnt_width(FILTER_LEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   pend_q, pend_d;
  logic                   ovr_q, ovr_d;
  logic                   s_sync, accept;
  logic                   rise, fall, hit, q;

  assign s_sync = sync_q[SYNC_STAGES-1];
  assign accept = (s_sync != level_q)
                && (cnt_q == CNT_LAST);
  assign rise   = accept & s_sync;
  assign fall   = accept & ~s_sync;

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = in_i;
    for (int k = 1; k < SYNC_STAGES; k++)
      sync_d[k] = sync_q[k-1];
  end

  always_comb begin
    cnt_d   = cnt_q + CW'(1);
    level_d = level_q;
    if (s_sync == level_q) begin
      cnt_d = '0;
    end else if (accept) begin
      cnt_d   = '0;
      level_d = s_sync;
    end
  end

  always_comb begin
    hit = 1'b0;
    unique case (mode_i)
      MODE_OFF:  hit = 1'b0;
      MODE_RISE: hit = rise;
      MODE_FALL: hit = fall;
      MODE_BOTH: hit = rise | fall;
    endcase
  end

  // Set beats clear so a coincident event is never lost.
  assign q      = ena_i & hit;
  assign rise_d = ena_i & rise;
  assign fall_d = ena_i & fall;
  assign pend_d = q | (pend_q & ~clr_i);
  assign ovr_d  = ~clr_i & (ovr_q | (q & pend_q));

  always_ff @(posedge clk) begin
    if (!nrst) begin
      sync_q  <= {SYNC_STAGES{RESET_LEVEL}};
      cnt_q   <= '0;
      level_q <= RESET_LEVEL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      pend_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
    end
  end

  assign level_o   = level_q;
  assign rising_o  = rise_q;
  assign falling_o = fall_q;
  assign pending_o = pend_q;
  assign overrun_o = ovr_q;

endmodule

// File: rtl/edge_event_capture.sv
// Multi-channel edge event capture front-end
// with a combined, maskable interrupt.
module edge_event_capture
  import edge_event_pkg::*;
#(
  parameter int   WIDTH       = 32,
  parameter int   SYNC_STAGES = 2,
  parameter int   FILTER_LEN  = 4,
  parameter logic RESET_LEVEL = 1'b0
) (
  input logic                 clk,
  input logic                 nrst,
  edge_event_capture_if.slave bus
);

  logic [WIDTH-1:0] level, rising, falling;
  logic [WIDTH-1:0] pending, overrun;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    edge_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN),
      .RESET_LEVEL (RESET_LEVEL)
    ) u_chan (
      .clk       (clk),
      .nrst      (nrst),
      .ena_i     (bus.ena),
      .in_i      (bus.in[i]),
      .mode_i    (bus.mode[2*i +: 2]),
      .clr_i     (bus.clr[i]),
      .level_o   (level[i]),
      .rising_o  (rising[i]),
      .falling_o (falling[i]),
      .pending_o (pending[i]),
      .overrun_o (overrun[i])
    );
  end

  assign bus.level   = level;
  assign bus.rising  = rising;
  assign bus.falling = falling;
  assign bus.both    = rising | falling;
  assign bus.pending = pending;
  assign bus.overrun = overrun;
  assign bus.irq     = |(pending & bus.irq_en);

endmodule

// File: tb/tb_edge_event_capture.sv
// Self-checking bench for edge_event_capture:
// directed scenarios plus random traffic against a model.
module tb_edge_event_capture;
  import edge_event_pkg::*;

  localparam int   W  = 32;
  localparam int   SY = 2;
  localparam int   FL = 4;
  localparam int   LAT = SY + FL;
  localparam logic RL = 1'b0;

  logic clk = 1'b0;
  logic nrst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  edge_event_capture_if #(.WIDTH(W)) bus ();

  edge_event_capture #(
    .WIDTH       (W),
    .SYNC_STAGES (SY),
    .FILTER_LEN  (FL),
    .RESET_LEVEL (RL)
  ) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  // Reference: the delayed input must disagree with the
  // accepted level for FL consecutive samples to flip it.
  logic [W-1:0] m_dly [SY];
  logic [W-1:0] m_lvl, m_rise, m_fall, m_pend, m_ovr;
  int           m_run [W];

  always @(posedge clk) begin : model
    automatic logic [W-1:0] s, acc, q;
    automatic int run_n [W];
    if (!nrst) begin
      for (int k = 0; k < SY; k++) m_dly[k] <= {W{RL}};
      for (int i = 0; i < W; i++) m_run[i] <= 0;
      m_lvl  <= {W{RL}};
      m_rise <= '0;
      m_fall <= '0;
      m_pend <= '0;
      m_ovr  <= '0;
    end else begin
      s   = m_dly[SY-1];
      acc = '0;
      q   = '0;
      for (int i = 0; i < W; i++) begin
        run_n[i] = (s[i] != m_lvl[i]) ? m_run[i] + 1 : 0;
        if (run_n[i] == FL) begin
          acc[i]   = 1'b1;
          run_n[i] = 0;
        end
        case (bus.mode[2*i +: 2])
          2'b01:   q[i] = acc[i] & s[i];
          2'b10:   q[i] = acc[i] & ~s[i];
          2'b11:   q[i] = acc[i];
          default: q[i] = 1'b0;
        endcase
      end
      if (!bus.ena) q = '0;
      for (int i = 0; i < W; i++) m_run[i] <= run_n[i];
      m_lvl  <= m_lvl ^ acc;
      m_rise <= bus.ena ? (acc & s) : '0;
      m_fall <= bus.ena ? (acc & ~s) : '0;
      m_pend <= q | (m_pend & ~bus.clr);
      m_ovr  <= (m_ovr | (q & m_pend)) & ~bus.clr;
      m_dly[0] <= bus.in;
      for (int k = 1; k < SY; k++) m_dly[k] <= m_dly[k-1];
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    logic [W-1:0] exp;
    @(negedge clk);
    nrst   = 1'b0;
    bus.in = '1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.level, bus.rising, bus.falling, bus.both,
           bus.pending, bus.overrun} !== '0 || bus.irq !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cyc %0d: level=%h rising=%h pending=%h irq=%b, required all 0",
                 k, bus.level, bus.rising, bus.pending, bus.irq);
      end
    end
    nrst = 1'b1;
    for (int k = 1; k <= LAT + 1; k++) begin
      @(negedge clk);
      exp = (k == LAT) ? '1 : '0;
      checks++;
      if (bus.rising !== exp) begin
        errors++;
        $display("FAIL reset_release edge %0d: rising=%h, required %h",
                 k, bus.rising, exp);
      end
    end
    checks++;
    if (bus.level !== '1) begin
      errors++;
      $display("FAIL reset_level: level=%h, required %h", bus.level, {W{1'b1}});
    end
  endtask

  task automatic test_glitch;
    bus.in = '0;
    step(8);
    bus.in[3] = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (k == 3) bus.in[3] = 1'b0;
      checks++;
      if (bus.rising[3] !== 1'b0 || bus.level[3] !== 1'b0) begin
        errors++;
        $display("FAIL glitch cyc %0d: rising3=%b level3=%b, required 0 0",
                 k, bus.rising[3], bus.level[3]);
      end
    end
    bus.in[3] = 1'b1;
    for (int k = 1; k <= LAT + 1; k++) begin
      @(negedge clk);
      checks++;
      if (bus.rising[3] !== (k == LAT) || bus.level[3] !== (k >= LAT)) begin
        errors++;
        $display("FAIL glitch_hold edge %0d: rising3=%b level3=%b, required %b %b",
                 k, bus.rising[3], bus.level[3], k == LAT, k >= LAT);
      end
    end
  endtask

  task automatic test_mode;
    logic [3:0] exp;
    bus.in = '0;
    step(8);
    bus.mode[7:0] = {MODE_OFF, MODE_BOTH, MODE_FALL, MODE_RISE};
    bus.in[3:0]   = 4'hF;
    for (int k = 1; k <= LAT + 1; k++) begin
      @(negedge clk);
      exp = (k == LAT) ? 4'hF : 4'h0;
      checks++;
      if (bus.rising[3:0] !== exp || bus.both[3:0] !== exp
          || bus.falling[3:0] !== 4'h0) begin
        errors++;
        $display("FAIL mode_rise edge %0d: rising=%h both=%h falling=%h, required %h %h 0",
                 k, bus.rising[3:0], bus.both[3:0], bus.falling[3:0], exp, exp);
      end
    end
    checks++;
    if (bus.pending[3:0] !== 4'b0101) begin
      errors++;
      $display("FAIL mode_pend_rise: pending=%b, required 0101", bus.pending[3:0]);
    end
    step(2);
    bus.in[3:0] = 4'h0;
    for (int k = 1; k <= LAT + 1; k++) begin
      @(negedge clk);
      exp = (k == LAT) ? 4'hF : 4'h0;
      checks++;
      if (bus.falling[3:0] !== exp || bus.rising[3:0] !== 4'h0) begin
        errors++;
        $display("FAIL mode_fall edge %0d: falling=%h rising=%h, required %h 0",
                 k, bus.falling[3:0], bus.rising[3:0], exp);
      end
    end
    checks++;
    if (bus.pending[3:0] !== 4'b0111) begin
      errors++;
      $display("FAIL mode_pend_fall: pending=%b, required 0111", bus.pending[3:0]);
    end
  endtask

  task automatic test_sticky;
    bus.mode[11:10] = MODE_BOTH;
    bus.irq_en      = '0;
    bus.irq_en[5]   = 1'b1;
    bus.in[5]       = 1'b1;
    step(LAT + 1);
    checks++;
    if (bus.pending[5] !== 1'b1 || bus.overrun[5] !== 1'b0 || bus.irq !== 1'b1) begin
      errors++;
      $display("FAIL sticky_first: pend=%b ovr=%b irq=%b, required 1 0 1",
               bus.pending[5], bus.overrun[5], bus.irq);
    end
    bus.in[5] = 1'b0;
    step(LAT + 1);
    checks++;
    if (bus.pending[5] !== 1'b1 || bus.overrun[5] !== 1'b1) begin
      errors++;
      $display("FAIL sticky_overrun: pend=%b ovr=%b, required 1 1",
               bus.pending[5], bus.overrun[5]);
    end
    bus.clr[5] = 1'b1;
    step(1);
    bus.clr[5] = 1'b0;
    checks++;
    if (bus.pending[5] !== 1'b0 || bus.overrun[5] !== 1'b0 || bus.irq !== 1'b0) begin
      errors++;
      $display("FAIL sticky_clear: pend=%b ovr=%b irq=%b, required 0 0 0",
               bus.pending[5], bus.overrun[5], bus.irq);
    end
    bus.in[5] = 1'b1;
    step(LAT + 1);
    bus.in[5] = 1'b0;
    step(LAT - 1);
    bus.clr[5] = 1'b1;
    step(1);
    bus.clr[5] = 1'b0;
    checks++;
    if (bus.falling[5] !== 1'b1 || bus.pending[5] !== 1'b1
        || bus.overrun[5] !== 1'b0) begin
      errors++;
      $display("FAIL sticky_set_vs_clr: fall=%b pend=%b ovr=%b, required 1 1 0",
               bus.falling[5], bus.pending[5], bus.overrun[5]);
    end
    bus.irq_en[5] = 1'b0;
    #1;
    checks++;
    if (bus.irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_mask: irq=%b, required 0", bus.irq);
    end
    bus.clr = '1;
    step(1);
    bus.clr = '0;
  endtask

  task automatic test_enable;
    bus.mode[15:14] = MODE_BOTH;
    bus.ena         = 1'b0;
    bus.in[7]       = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.rising[7], bus.falling[7], bus.both[7], bus.pending[7]} !== 4'b0) begin
        errors++;
        $display("FAIL ena_off cyc %0d: r=%b f=%b b=%b pend=%b, required 0",
                 k, bus.rising[7], bus.falling[7], bus.both[7], bus.pending[7]);
      end
    end
    checks++;
    if (bus.level[7] !== 1'b1) begin
      errors++;
      $display("FAIL ena_level: level7=%b, required 1", bus.level[7]);
    end
    bus.ena = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.rising[7], bus.falling[7], bus.pending[7]} !== 3'b0) begin
        errors++;
        $display("FAIL ena_reenable cyc %0d: r=%b f=%b pend=%b, required 0",
                 k, bus.rising[7], bus.falling[7], bus.pending[7]);
      end
    end
  endtask

  task automatic test_midreset;
    bus.in[9] = 1'b1;
    step(4);
    nrst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.level[9] !== RL || bus.rising[9] !== 1'b0) begin
      errors++;
      $display("FAIL midreset: level9=%b rising9=%b, required %b 0",
               bus.level[9], bus.rising[9], RL);
    end
    step(1);
    nrst = 1'b1;
    for (int k = 1; k <= LAT + 1; k++) begin
      @(negedge clk);
      checks++;
      if (bus.rising[9] !== (k == LAT)) begin
        errors++;
        $display("FAIL midreset_release edge %0d: rising9=%b, required %b",
                 k, bus.rising[9], k == LAT);
      end
    end
  endtask

  task automatic test_random;
    logic irq_exp;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      irq_exp = |(m_pend & bus.irq_en);
      checks++;
      if (bus.level !== m_lvl || bus.rising !== m_rise || bus.falling !== m_fall) begin
        errors++;
        $display("FAIL rnd_edges cyc %0d: lvl=%h r=%h f=%h, required %h %h %h",
                 c, bus.level, bus.rising, bus.falling, m_lvl, m_rise, m_fall);
      end
      checks++;
      if (bus.both !== (m_rise | m_fall)) begin
        errors++;
        $display("FAIL rnd_both cyc %0d: both=%h, required %h",
                 c, bus.both, m_rise | m_fall);
      end
      checks++;
      if (bus.pending !== m_pend || bus.overrun !== m_ovr || bus.irq !== irq_exp) begin
        errors++;
        $display("FAIL rnd_flags cyc %0d: pend=%h ovr=%h irq=%b, required %h %h %b",
                 c, bus.pending, bus.overrun, bus.irq, m_pend, m_ovr, irq_exp);
      end
      bus.in  = bus.in ^ ($urandom & $urandom & $urandom);
      bus.clr = $urandom & $urandom & $urandom & $urandom;
      bus.ena = ($urandom_range(0, 9) != 0);
      nrst    = ($urandom_range(0, 399) != 0);
      if (c % 64 == 0) begin
        bus.mode   = {$urandom, $urandom};
        bus.irq_en = $urandom;
      end
    end
    @(negedge clk);
    nrst    = 1'b1;
    bus.clr = '0;
  endtask

  initial begin
    nrst       = 1'b0;
    bus.ena    = 1'b1;
    bus.in     = '0;
    bus.mode   = '0;
    bus.clr    = '0;
    bus.irq_en = '0;
    test_reset();
    test_glitch();
    test_mode();
    test_sticky();
    test_enable();
    test_midreset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/edge_event_capture.md
Name: edge_event_capture

Overview:
Multi-channel, parametrised edge detector for asynchronous or noisy inputs. Each of WIDTH channels has:
- a synchroniser;
- a debounce filter;
- raw rising/falling/both pulse outputs;
- a per-channel edge-mode select;
- a sticky pending flag with clear, and an overrun flag;
- a combined interrupt output.

It is the standard front-end between external pins or cross-domain strobes and the system's event/interrupt logic.

Parameters:
- WIDTH, 32, number of independent channels.
- SYNC_STAGES, 2, synchroniser flops per channel (legal range 1..4).
- FILTER_LEN, 4, consecutive stable cycles needed to accept a new level (legal range ≥1; 1 = no filtering).
- RESET_LEVEL, 1'b0, level loaded into the synchroniser and filtered state at reset. Applies to all channels.

Ports:
- clk, input, 1, sole clock.
- nrst, input, 1, reset, synchronous, active-low.
- ena, input, 1, global enable for pulses and flag setting.
- in, input, WIDTH, raw channel inputs; may be asynchronous.
- mode, input, 2*WIDTH, per-channel qualifier in bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both.
- clr, input, WIDTH, per-channel clear pulse for pending and overrun.
- irq_en, input, WIDTH, per-channel interrupt mask.
- level, output, WIDTH, filtered, debounced channel level.
- rising, output, WIDTH, one-cycle pulse on an accepted 0->1 transition.
- falling, output, WIDTH, one-cycle pulse on an accepted 1->0 transition.
- both, output, WIDTH, rising | falling.
- pending, output, WIDTH, sticky flag set by a mode-qualified event.
- overrun, output, WIDTH, sticky flag set by a qualified event while pending is already 1.
- irq, output, 1, |(pending & irq_en).

Behaviour:
- Reset: when nrst=0 at a clk edge, the following are loaded:
  - synchroniser flops and level = {WIDTH{RESET_LEVEL}};
  - filter counters = 0;
  - rising, falling, both, pending, overrun = 0.
  - irq is therefore 0 one edge after reset. Reset mid-operation aborts any in-progress filter count, and no edge is reported for the reset-induced level change.
- Synchroniser: a SYNC_STAGES-deep shift register per channel; the filter sees its last stage, s_sync.
- Filter: a per-channel counter cnt of width $clog2(FILTER_LEN+1).
  - If s_sync == level, cnt <= 0.
  - Otherwise, if cnt == FILTER_LEN-1, then level <= s_sync and cnt <= 0.
  - Otherwise cnt <= cnt+1.
  - A glitch shorter than FILTER_LEN cycles is never accepted.
- Edge pulses: registered in the same edge that updates level.
  - rising[i] = accept & s_sync; falling[i] = accept & ~s_sync; both = rising | falling.
  - Each pulse is exactly one cycle wide.
  - Latency: SYNC_STAGES + FILTER_LEN clk edges from the first edge sampling the new stable input level to the pulse being visible.
- ena=0:
  - rising, falling and both are forced 0, and pending/overrun are not set.
  - The synchroniser, filter and level keep tracking, so re-enabling never produces a stale edge.
  - clr still operates.
- Qualified event: q[i] = ena & ((mode=01 & rise) | (mode=10 & fall) | (mode=11 & (rise|fall))), where rise/fall are the next-state values of rising[i]/falling[i]. mode=00 never qualifies. The rising/falling/both outputs are independent of mode.
- Pending: pending[i] <= q[i] ? 1 : (clr[i] ? 0 : pending[i]).
  - Simultaneous q and clr: set wins, so the event is not lost.
  - Pending becomes visible in the same edge as the corresponding pulse.
- Overrun: set when q[i] & pending[i] (current value), unless clr[i] is asserted that same cycle. clr[i] alone clears it. A set with simultaneous clr leaves overrun 0 and pending 1.
- mode changes take effect on the next edge and never retroactively set flags.
- irq: combinational from the registered pending and the irq_en input.

Decomposition:
- Package edge_event_pkg holds:
  - mode encoding constants MODE_OFF / MODE_RISE / MODE_FALL / MODE_BOTH;
  - the function for the counter width.
- One natural sub-module, edge_chan, covering a single channel's synchroniser, filter, pulse and flag logic. The top instantiates WIDTH copies via generate and reduces irq.

Test Plan:
- Reset and idle: hold nrst=0 for 3 cycles with in=32'hFFFF_FFFF, RESET_LEVEL=0, then release. Required: all outputs 0 during reset; after release, rising=32'hFFFF_FFFF exactly SYNC_STAGES+FILTER_LEN=6 edges later, for one cycle.
- Glitch filter: on channel 3, pulse in high for 3 cycles, then hold it high. Required: no pulse from the 3-cycle glitch; level[3]=1 and a single rising[3] pulse 6 edges after the hold begins.
- Mode qualification: set mode ch0=01, ch1=10, ch2=11, ch3=00, then toggle in[3:0] 0->1->0 with gaps over 10 cycles.
  - pending[3:0] = 4'b0101 after the rise and 4'b0111 after the fall.
  - rising/falling pulse on all 4 channels regardless of mode.
- Sticky, clear and overrun on ch5 (mode=11, irq_en[5]=1):
  - First edge: pending[5]=1 and irq=1.
  - Second edge without clr: overrun[5]=1.
  - clr[5] pulse: both flags go 0 and irq goes 0.
  - Edge coincident with clr: pending[5]=1 and overrun[5]=0.
- Enable gating: with ena=0, toggle in[7]. Required: no pulses and pending[7]=0, while level[7] still follows in. Set ena=1 with no further input change. Required: no pulse and pending[7] stays 0.
- Mid-operation reset: assert nrst=0 while the ch9 filter counter is at 2. Required: level[9] returns to RESET_LEVEL and no pulse appears; after release, the full 6-edge latency applies again.
